// File: rtl/ahbl_sram_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_sram_slave_pkg
// Description : Shared AHB-Lite types, bus widths and the byte-enable helper
//               used by the SRAM slave.
// Revision    : 1.0 - initial release
// ============================================================================
package ahbl_sram_slave_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic {
        AHBL_OKAY  = 1'b0,
        AHBL_ERROR = 1'b1
    } ahbl_resp_e;

    // Byte lanes touched by a transfer; sizes above a word are treated as a word.
    function automatic logic [3:0] ahbl_be(input logic [2:0] hsize, input logic [1:0] addr);
        logic [3:0] be;
        case (hsize)
            HSIZE_BYTE: be = 4'b0001 << addr;
            HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahbl_sram_slave_sp_sram.sv
`default_nettype none
// ============================================================================
// Module      : sp_sram
// Description : Single-port 32-bit synchronous SRAM. One read or one
//               byte-masked write per cycle, read data registered (1 cycle).
//               INIT_FILE is accepted for interface compatibility only.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_sram #(
    parameter int    DEPTH     = 16384,
    parameter string INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     rd_en,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [3:0]               wr_be,
    input  logic [31:0]              wr_data,
    output logic [31:0]              rd_data
);

    logic [31:0] mem [DEPTH];

    // Byte-masked write and registered read share the single address port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahbl_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_sram_slave
// Description : AHB-Lite slave in front of a single-port SRAM. Writes are
//               posted into a one-word buffer so a write followed directly by
//               a read runs without wait states; reads that hit the buffer
//               are merged byte by byte. Optional wait states per transfer.
//               Macro AHBL_SRAM_ERR_EN: out-of-range addresses get a two-cycle
//               ERROR response; otherwise addresses alias modulo MEM_BYTES.
// Revision    : 1.0 - initial release
// ============================================================================
module ahbl_sram_slave
    import ahbl_sram_slave_pkg::*;
#(
    parameter int    MEM_BYTES   = 65536,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,
    input  logic                  hsel_i,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  logic [1:0]            htrans_i,
    input  logic                  hwrite_i,
    input  logic [2:0]            hsize_i,
    input  logic [2:0]            hburst_i,
    input  logic [3:0]            hprot_i,
    input  logic                  hmastlock_i,
    input  logic [DATA_WIDTH-1:0] hwdata_i,
    input  logic                  hready_i,
    output logic [DATA_WIDTH-1:0] hrdata_o,
    output logic                  hreadyout_o,
    output logic                  hresp_o
);

    localparam int         MEM_AW   = $clog2(MEM_BYTES);
    localparam int         IDX_W    = MEM_AW - 2;
    localparam logic [3:0] WS       = 4'(WAIT_STATES);
    localparam bit         HAS_WAIT = (WAIT_STATES > 0);

    // State describes the data phase currently on the bus.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

    state_e                state;
    state_e                state_nxt;
    logic [3:0]            wait_cnt;

    logic                  ph_write;
    logic [IDX_W-1:0]      ph_idx;
    logic [3:0]            ph_be;

    logic                  buf_valid;
    logic [IDX_W-1:0]      buf_idx;
    logic [3:0]            buf_be;
    logic [DATA_WIDTH-1:0] buf_data;

    logic [DATA_WIDTH-1:0] rd_hold;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] merged;

    logic                  slave_free;
    logic                  accept;
    logic                  addr_oob;
    logic                  accept_ok;
    logic                  accept_err;
    logic [IDX_W-1:0]      acc_idx;
    logic [3:0]            acc_be;

    logic                  rd_issue_now;
    logic                  rd_issue_late;
    logic                  rd_issue;
    logic                  capture;
    logic                  direct_wr;
    logic                  drain;
    logic                  rd_data_phase;
    logic                  buf_hit;

    logic                  mem_re;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_addr;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic                  unused_inputs;

    assign unused_inputs = ^{htrans_i[0], hburst_i, hprot_i, hmastlock_i,
                             haddr_i[ADDR_WIDTH-1:MEM_AW]};

    // A new address phase can only complete while this slave is not stalling.
    assign slave_free = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
    assign accept     = hsel_i & htrans_i[1] & hready_i & slave_free;

`ifdef AHBL_SRAM_ERR_EN
    assign addr_oob = |haddr_i[ADDR_WIDTH-1:MEM_AW];
`else
    assign addr_oob = 1'b0;
`endif

    assign accept_ok  = accept & ~addr_oob;
    assign accept_err = accept & addr_oob;
    assign acc_idx    = haddr_i[MEM_AW-1:2];
    assign acc_be     = ahbl_be(hsize_i, haddr_i[1:0]);

    // Reads are launched one cycle before their ready data cycle.
    assign rd_issue_now  = accept_ok & ~hwrite_i & ~HAS_WAIT;
    assign rd_issue_late = (state == ST_WAIT) && (wait_cnt == 4'd1) && !ph_write;
    assign rd_issue      = rd_issue_now | rd_issue_late;

    // Write data arrives in the ready data cycle of a write transfer.
    assign capture = (state == ST_DATA) && ph_write;

    // When another write is accepted alongside this capture, the port is free
    // now but may be taken by a read next cycle while that write is captured;
    // writing straight through keeps the buffer empty for it, so neither
    // transfer ever has to stall. Otherwise the write is posted.
    assign direct_wr = capture & ~rd_issue & ~buf_valid & accept_ok & hwrite_i;
    assign drain     = buf_valid & ~rd_issue;

    assign mem_re    = rd_issue & ~sys_rst_i;
    assign mem_we    = (drain | direct_wr) & ~sys_rst_i;
    assign mem_addr  = rd_issue_late ? ph_idx  :
                       rd_issue_now  ? acc_idx :
                       drain         ? buf_idx : ph_idx;
    assign mem_be    = drain ? buf_be   : ph_be;
    assign mem_wdata = drain ? buf_data : hwdata_i;

    sp_sram #(
        .DEPTH     (MEM_BYTES / 4),
        .INIT_FILE (INIT_FILE)
    ) u_sram (
        .clk     (sys_clk_i),
        .rd_en   (mem_re),
        .wr_en   (mem_we),
        .addr    (mem_addr),
        .wr_be   (mem_be),
        .wr_data (mem_wdata),
        .rd_data (mem_rdata)
    );

    // Posted bytes override SRAM bytes so reads see the newest write.
    assign rd_data_phase = (state == ST_DATA) && !ph_write;
    assign buf_hit       = buf_valid && (buf_idx == ph_idx);

    generate
        for (genvar i = 0; i < 4; i++) begin : g_merge
            assign merged[8*i +: 8] = (buf_hit && buf_be[i]) ? buf_data[8*i +: 8]
                                                             : mem_rdata[8*i +: 8];
        end
    endgenerate

    assign hrdata_o = rd_data_phase ? merged : rd_hold;

    // State register and wait-state counter.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (accept_ok && HAS_WAIT) begin
                wait_cnt <= WS;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt   = state;
        hreadyout_o = 1'b1;
        hresp_o     = AHBL_OKAY;
        case (state)
            ST_WAIT: begin
                hreadyout_o = 1'b0;
                if (wait_cnt == 4'd1) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_ERR1: begin
                hreadyout_o = 1'b0;
`ifdef AHBL_SRAM_ERR_EN
                hresp_o     = AHBL_ERROR;
`endif
                state_nxt   = ST_ERR2;
            end
            default: begin
`ifdef AHBL_SRAM_ERR_EN
                if (state == ST_ERR2) begin
                    hresp_o = AHBL_ERROR;
                end
`endif
                if (accept_err) begin
                    state_nxt = ST_ERR1;
                end else if (accept_ok) begin
                    state_nxt = HAS_WAIT ? ST_WAIT : ST_DATA;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // Address-phase attributes held for the data phase.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            ph_write <= 1'b0;
            ph_idx   <= '0;
            ph_be    <= 4'd0;
        end else if (accept) begin
            ph_write <= hwrite_i;
            ph_idx   <= acc_idx;
            ph_be    <= acc_be;
        end
    end

    // Posted-write buffer: load on capture, clear when drained to SRAM.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            buf_valid <= 1'b0;
            buf_idx   <= '0;
            buf_be    <= 4'd0;
            buf_data  <= '0;
        end else if (capture && !direct_wr) begin
            buf_valid <= 1'b1;
            buf_idx   <= ph_idx;
            buf_be    <= ph_be;
            buf_data  <= hwdata_i;
        end else if (drain) begin
            buf_valid <= 1'b0;
        end
    end

    // Read data is held between read data phases.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            rd_hold <= '0;
        end else if (rd_data_phase) begin
            rd_hold <= merged;
        end
    end

endmodule
`default_nettype wire
